// File: rtl/serial_subtractor_if.sv
// serial_subtractor_if: operand (a/b) and result (diff/borrow) valid-ready bundle.
// master drives in_valid/a/b/out_ready; slave returns in_ready/out_valid/diff/borrow.
interface serial_subtractor_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             borrow;

  modport master (
    output in_valid,
    output a,
    output b,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  diff,
    input  borrow
  );

  modport slave (
    input  in_valid,
    input  a,
    input  b,
    input  out_ready,
    output in_ready,
    output out_valid,
    output diff,
    output borrow
  );
endinterface

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial a-b, LSB first; ports clk, rst_n (async low), bus (slave).
// SERSUB_ABSDIFF_EN adds a FIX cycle so diff=|a-b|; borrow still flags a<b.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input logic               clk,
  input logic               rst_n,
  serial_subtractor_if.slave bus
);

  localparam int CW = $clog2(WIDTH);

`ifdef SERSUB_ABSDIFF_EN
  typedef enum logic [1:0] {
    IDLE, RUN, FIX, DONE
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE, RUN, DONE
  } state_t;
`endif

  state_t           state;
  state_t           state_n;
  logic             up_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] r_q;
  logic [CW-1:0]    cnt;
  logic             bi;
  logic             bo_q;
  logic             ov_q;
  logic             x;
  logic             y;
  logic             d;
  logic             bi_n;
  logic             acc;
  logic             last;

  // up_q keeps in_ready low until the first edge after reset
  assign bus.in_ready  = up_q & (state == IDLE);
  assign bus.out_valid = ov_q;
  assign bus.diff      = r_q;
  assign bus.borrow    = bo_q;

  assign acc  = bus.in_valid & bus.in_ready;
  assign last = (cnt == CW'(WIDTH - 1));
  assign x    = a_q[0];
  assign y    = b_q[0];
  assign d    = x ^ y ^ bi;
  assign bi_n = (~x & y) | (~(x ^ y) & bi);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: if (acc) state_n = RUN;
`ifdef SERSUB_ABSDIFF_EN
      RUN:  if (last) state_n = FIX;
      FIX:  state_n = DONE;
`else
      RUN:  if (last) state_n = DONE;
`endif
      DONE: if (bus.out_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      up_q <= 1'b0;
      a_q  <= '0;
      b_q  <= '0;
      r_q  <= '0;
      cnt  <= '0;
      bi   <= 1'b0;
      bo_q <= 1'b0;
      ov_q <= 1'b0;
    end else begin
      up_q <= 1'b1;
      ov_q <= (state_n == DONE);
      if (acc) begin
        a_q <= bus.a;
        b_q <= bus.b;
        cnt <= '0;
        bi  <= 1'b0;
      end else if (state == RUN) begin
        a_q <= a_q >> 1;
        b_q <= b_q >> 1;
        r_q <= {d, r_q[WIDTH-1:1]};
        bi  <= bi_n;
        cnt <= cnt + CW'(1);
        if (last) bo_q <= bi_n;
      end
`ifdef SERSUB_ABSDIFF_EN
      else if (state == FIX && bo_q) begin
        r_q <= ~r_q + WIDTH'(1);
      end
`endif
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: random + directed checks of serial_subtractor
// against an arithmetic model, at WIDTH=8 and WIDTH=16.
module tb_serial_subtractor;

`ifdef SERSUB_ABSDIFF_EN
  localparam int XL = 1;
`else
  localparam int XL = 0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  bit          sel;
  logic        iv;
  logic        ordy;
  logic [15:0] av;
  logic [15:0] bv;
  logic        ir;
  logic        ov;
  logic        bo;
  logic [15:0] df;
  int          checks = 0;
  int          errors = 0;

  serial_subtractor_if #(.WIDTH(8))  if8 ();
  serial_subtractor_if #(.WIDTH(16)) if16 ();

  serial_subtractor #(.WIDTH(8)) u8 (
    .clk(clk), .rst_n(rst_n), .bus(if8)
  );
  serial_subtractor #(.WIDTH(16)) u16 (
    .clk(clk), .rst_n(rst_n), .bus(if16)
  );

  assign if8.in_valid   = iv & ~sel;
  assign if8.a          = av[7:0];
  assign if8.b          = bv[7:0];
  assign if8.out_ready  = ordy;
  assign if16.in_valid  = iv & sel;
  assign if16.a         = av;
  assign if16.b         = bv;
  assign if16.out_ready = ordy;

  assign ir = sel ? if16.in_ready  : if8.in_ready;
  assign ov = sel ? if16.out_valid : if8.out_valid;
  assign bo = sel ? if16.borrow    : if8.borrow;
  assign df = sel ? if16.diff      : {8'h00, if8.diff};

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic do_op(input bit s, input logic [15:0] xi,
                       input logic [15:0] yi, input int bp);
    int          w;
    int          lat;
    int          n;
    logic [15:0] xa;
    logic [15:0] ya;
    logic [15:0] ed;
    logic        eb;
    w  = s ? 16 : 8;
    xa = s ? xi : {8'h00, xi[7:0]};
    ya = s ? yi : {8'h00, yi[7:0]};
    eb = (xa < ya);
`ifdef SERSUB_ABSDIFF_EN
    ed = eb ? ya - xa : xa - ya;
`else
    ed = xa - ya;
    if (!s) ed[15:8] = 8'h00;
`endif
    sel  = s;
    ordy = (bp == 0);
    #1;
    n = 0;
    while (!ir && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("in_ready", 64'(ir), 64'(1));
    iv = 1'b1;
    av = xa;
    bv = ya;
    @(negedge clk);
    iv = 1'b0;
    av = 16'($urandom);
    bv = 16'($urandom);
    lat = 0;
    while (!ov && lat < 80) begin
      @(negedge clk);
      lat++;
    end
    chk("latency", 64'(lat), 64'(w + XL));
    chk("diff", 64'(df), 64'(ed));
    chk("borrow", 64'(bo), 64'(eb));
    for (int i = 0; i < bp; i++) begin
      iv = 1'($urandom);
      av = 16'($urandom);
      bv = 16'($urandom);
      @(negedge clk);
      chk("bp_valid", 64'(ov), 64'(1));
      chk("bp_diff", 64'(df), 64'(ed));
      chk("bp_borrow", 64'(bo), 64'(eb));
      chk("bp_ready", 64'(ir), 64'(0));
    end
    iv   = 1'b0;
    ordy = 1'b1;
    @(negedge clk);
    chk("drain", 64'(ov), 64'(0));
    chk("idle_ready", 64'(ir), 64'(1));
  endtask

  initial begin
    bit seen;
    rst_n = 1'b0;
    sel   = 1'b0;
    iv    = 1'b0;
    ordy  = 1'b0;
    av    = '0;
    bv    = '0;
    repeat (2) @(negedge clk);
    chk("rst_ready", 64'(ir), 64'(0));
    chk("rst_valid", 64'(ov), 64'(0));
    chk("rst_diff", 64'(df), 64'(0));
    chk("rst_borrow", 64'(bo), 64'(0));
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", 64'(ir), 64'(1));

    do_op(1'b0, 16'd200, 16'd55, 0);
    do_op(1'b0, 16'd5, 16'd9, 0);
    do_op(1'b0, 16'h00A5, 16'h00A5, 0);
    do_op(1'b0, 16'd0, 16'd0, 0);
    do_op(1'b0, 16'd77, 16'd130, 5);

    sel  = 1'b0;
    ordy = 1'b1;
    iv   = 1'b1;
    av   = 16'd200;
    bv   = 16'd55;
    @(negedge clk);
    iv = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_valid", 64'(ov), 64'(0));
    chk("mid_diff", 64'(df), 64'(0));
    chk("mid_borrow", 64'(bo), 64'(0));
    chk("mid_ready", 64'(ir), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    seen  = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ov) seen = 1'b1;
    end
    chk("no_result", 64'(seen), 64'(0));
    do_op(1'b0, 16'd10, 16'd3, 0);

    do_op(1'b1, 16'd0, 16'd1, 0);
    for (int k = 0; k < 1000; k++) begin
      do_op(1'b1, 16'($urandom), 16'($urandom),
            ($urandom_range(0, 9) == 0) ?
              int'($urandom_range(1, 3)) : 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
